exu_longp_wbck_sched: RTL and testbench

- Outstanding-instruction tracker and write-back scheduler for the EXU long pipe (LSU, NICE coprocessor).
- Allocates an itag at dispatch for each long-pipe instruction and reports RAW/WAW hazards to dispatch.
- Retires long-pipe results strictly in program order, and arbitrates the single regfile write port between long-pipe results and ALU results. Long-pipe results win.
- Sits between EXU dispatch, the LSU/NICE write-back interfaces, the regfile write port and the commit exception path.

---
 rtl/exu_longp_pkg.sv | 24 ++
 rtl/exu_oitf_fifo.sv | 86 ++++++++
 rtl/exu_longp_wbck_sched.sv | 146 ++++++++++++++
 tb/tb_exu_longp_wbck_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_longp_pkg.sv
// Shared types for the EXU long-pipe write-back scheduler: itag sizing,
// source-select encoding and the outstanding-entry record.
package exu_longp_pkg;

  localparam int DATA_W = 32;
  localparam int RIDX_W = 5;

  function automatic int itag_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LSU,
    SEL_NICE
  } src_sel_e;

  typedef struct packed {
    logic              vld;
    logic              rdwen;
    logic [RIDX_W-1:0] rdidx;
  } oitf_entry_t;

endpackage

// File: rtl/exu_oitf_fifo.sv
// Outstanding-instruction FIFO: pointer/flag state, per-entry rd record,
// full/empty and the RAW/WAW compare against every pending destination.
module exu_oitf_fifo
  import exu_longp_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ITAG_W = itag_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_rdwen,
  input  logic [RIDX_W-1:0] push_rdidx,
  input  logic              pop,
  input  logic              rs1en,
  input  logic [RIDX_W-1:0] rs1idx,
  input  logic              rs2en,
  input  logic [RIDX_W-1:0] rs2idx,
  output logic              full,
  output logic              empty,
  output logic [ITAG_W-1:0] wr_itag,
  output logic [ITAG_W-1:0] rd_itag,
  output logic              head_rdwen,
  output logic [RIDX_W-1:0] head_rdidx,
  output logic              dep_raw,
  output logic              dep_waw
);

  // MSB of each pointer is the wrap flag; DEPTH is a power of two so the
  // natural carry out of the index bits toggles it.
  logic [ITAG_W:0]   wr_ptr;
  logic [ITAG_W:0]   rd_ptr;
  logic [ITAG_W-1:0] wr_idx;
  logic [ITAG_W-1:0] rd_idx;
  oitf_entry_t       ent [DEPTH];

  assign wr_idx  = wr_ptr[ITAG_W-1:0];
  assign rd_idx  = rd_ptr[ITAG_W-1:0];
  assign wr_itag = wr_idx;
  assign rd_itag = rd_idx;

  assign full  = (wr_idx == rd_idx) && (wr_ptr[ITAG_W] != rd_ptr[ITAG_W]);
  assign empty = (wr_ptr == rd_ptr);

  assign head_rdwen = ent[rd_idx].rdwen;
  assign head_rdidx = ent[rd_idx].rdidx;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent[i].vld <= 1'b0;
      end
    end else begin
      if (push) begin
        ent[wr_idx].vld   <= 1'b1;
        ent[wr_idx].rdwen <= push_rdwen;
        ent[wr_idx].rdidx <= push_rdidx;
        wr_ptr            <= wr_ptr + {{ITAG_W{1'b0}}, 1'b1};
      end
      if (pop) begin
        ent[rd_idx].vld <= 1'b0;
        rd_ptr          <= rd_ptr + {{ITAG_W{1'b0}}, 1'b1};
      end
    end
  end

  // x0 is deliberately compared like any other register.
  always_comb begin
    dep_raw = 1'b0;
    dep_waw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent[i].vld && ent[i].rdwen) begin
        if ((rs1en && (ent[i].rdidx == rs1idx)) ||
            (rs2en && (ent[i].rdidx == rs2idx))) begin
          dep_raw = 1'b1;
        end
        if (push_rdwen && (ent[i].rdidx == push_rdidx)) begin
          dep_waw = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exu_longp_wbck_sched.sv
// Long-pipe write-back scheduler: in-order retire of LSU/NICE results and
// arbitration of the single regfile write port against the ALU.
module exu_longp_wbck_sched
  import exu_longp_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ITAG_W = itag_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic              disp_rdwen,
  input  logic [RIDX_W-1:0] disp_rdidx,
  output logic [ITAG_W-1:0] disp_itag,
  input  logic              disp_rs1en,
  input  logic              disp_rs2en,
  input  logic [RIDX_W-1:0] disp_rs1idx,
  input  logic [RIDX_W-1:0] disp_rs2idx,
  output logic              dep_raw,
  output logic              dep_waw,
  output logic              oitf_empty,
  input  logic              lsu_wbck_valid,
  output logic              lsu_wbck_ready,
  input  logic [DATA_W-1:0] lsu_wbck_wdat,
  input  logic [ITAG_W-1:0] lsu_wbck_itag,
  input  logic              lsu_wbck_err,
  input  logic              nice_wbck_valid,
  output logic              nice_wbck_ready,
  input  logic [DATA_W-1:0] nice_wbck_wdat,
  input  logic [ITAG_W-1:0] nice_wbck_itag,
  input  logic              nice_wbck_err,
  input  logic              alu_wbck_valid,
  output logic              alu_wbck_ready,
  input  logic [DATA_W-1:0] alu_wbck_wdat,
  input  logic [RIDX_W-1:0] alu_wbck_rdidx,
  output logic              rf_wen,
  input  logic              rf_ready,
  output logic [DATA_W-1:0] rf_wdat,
  output logic [RIDX_W-1:0] rf_rdidx,
  output logic              excp_valid,
  input  logic              excp_ready,
  output logic [ITAG_W-1:0] excp_itag
);

  logic              full;
  logic              empty;
  logic              disp_fire;
  logic              retire;
  logic [ITAG_W-1:0] head_itag;
  logic              head_rdwen;
  logic [RIDX_W-1:0] head_rdidx;
  src_sel_e          sel;
  logic              lp_act;
  logic [DATA_W-1:0] sel_wdat;
  logic              sel_err;

  // No same-cycle bypass: a retire does not free the slot for this dispatch.
  assign disp_ready = !full;
  assign disp_fire  = disp_valid && !full;
  assign oitf_empty = empty;
  assign excp_itag  = head_itag;

  exu_oitf_fifo #(
    .DEPTH  (DEPTH),
    .ITAG_W (ITAG_W)
  ) u_oitf (
    .clk        (clk),
    .rst        (rst),
    .push       (disp_fire),
    .push_rdwen (disp_rdwen),
    .push_rdidx (disp_rdidx),
    .pop        (retire),
    .rs1en      (disp_rs1en),
    .rs1idx     (disp_rs1idx),
    .rs2en      (disp_rs2en),
    .rs2idx     (disp_rs2idx),
    .full       (full),
    .empty      (empty),
    .wr_itag    (disp_itag),
    .rd_itag    (head_itag),
    .head_rdwen (head_rdwen),
    .head_rdidx (head_rdidx),
    .dep_raw    (dep_raw),
    .dep_waw    (dep_waw)
  );

  // Only a result tagged with the head may proceed; LSU wins a (illegal) tie.
  always_comb begin
    sel = SEL_NONE;
    if (!empty) begin
      if (lsu_wbck_valid && (lsu_wbck_itag == head_itag)) begin
        sel = SEL_LSU;
      end else if (nice_wbck_valid && (nice_wbck_itag == head_itag)) begin
        sel = SEL_NICE;
      end
    end
  end

  assign lp_act = (sel != SEL_NONE);

  always_comb begin
    sel_wdat = lsu_wbck_wdat;
    sel_err  = lsu_wbck_err;
    if (sel == SEL_NICE) begin
      sel_wdat = nice_wbck_wdat;
      sel_err  = nice_wbck_err;
    end
  end

  always_comb begin
    rf_wen         = 1'b0;
    rf_wdat        = alu_wbck_wdat;
    rf_rdidx       = alu_wbck_rdidx;
    excp_valid     = 1'b0;
    retire         = 1'b0;
    alu_wbck_ready = 1'b0;
    if (lp_act) begin
      excp_valid = sel_err;
      rf_wen     = !sel_err && head_rdwen;
      rf_wdat    = sel_wdat;
      rf_rdidx   = head_rdidx;
      if (sel_err) begin
        retire = excp_ready;
      end else if (head_rdwen) begin
        retire = rf_ready;
      end else begin
        retire = 1'b1;
      end
    end else begin
      rf_wen         = alu_wbck_valid;
      alu_wbck_ready = rf_ready;
    end
    // Requests pending across a reset must not see a handshake.
    if (rst) begin
      rf_wen         = 1'b0;
      excp_valid     = 1'b0;
      retire         = 1'b0;
      alu_wbck_ready = 1'b0;
    end
  end

  assign lsu_wbck_ready  = retire && (sel == SEL_LSU);
  assign nice_wbck_ready = retire && (sel == SEL_NICE);

endmodule

// File: tb/tb_exu_longp_wbck_sched.sv
// Randomized scoreboard bench for exu_longp_wbck_sched: a program-order
// model of outstanding instructions predicts itags, hazards and retire events.
module tb_exu_longp_wbck_sched;

  localparam int DEPTH  = 4;
  localparam int ITAG_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_valid, disp_ready, disp_rdwen;
  logic [4:0]        disp_rdidx;
  logic [ITAG_W-1:0] disp_itag;
  logic              disp_rs1en, disp_rs2en;
  logic [4:0]        disp_rs1idx, disp_rs2idx;
  logic              dep_raw, dep_waw, oitf_empty;
  logic              lsu_wbck_valid, lsu_wbck_ready, lsu_wbck_err;
  logic [31:0]       lsu_wbck_wdat;
  logic [ITAG_W-1:0] lsu_wbck_itag;
  logic              nice_wbck_valid, nice_wbck_ready, nice_wbck_err;
  logic [31:0]       nice_wbck_wdat;
  logic [ITAG_W-1:0] nice_wbck_itag;
  logic              alu_wbck_valid, alu_wbck_ready;
  logic [31:0]       alu_wbck_wdat;
  logic [4:0]        alu_wbck_rdidx;
  logic              rf_wen, rf_ready;
  logic [31:0]       rf_wdat;
  logic [4:0]        rf_rdidx;
  logic              excp_valid, excp_ready;
  logic [ITAG_W-1:0] excp_itag;

  exu_longp_wbck_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rdwen(disp_rdwen),
    .disp_rdidx(disp_rdidx), .disp_itag(disp_itag),
    .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en),
    .disp_rs1idx(disp_rs1idx), .disp_rs2idx(disp_rs2idx),
    .dep_raw(dep_raw), .dep_waw(dep_waw), .oitf_empty(oitf_empty),
    .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
    .lsu_wbck_wdat(lsu_wbck_wdat), .lsu_wbck_itag(lsu_wbck_itag), .lsu_wbck_err(lsu_wbck_err),
    .nice_wbck_valid(nice_wbck_valid), .nice_wbck_ready(nice_wbck_ready),
    .nice_wbck_wdat(nice_wbck_wdat), .nice_wbck_itag(nice_wbck_itag), .nice_wbck_err(nice_wbck_err),
    .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
    .alu_wbck_wdat(alu_wbck_wdat), .alu_wbck_rdidx(alu_wbck_rdidx),
    .rf_wen(rf_wen), .rf_ready(rf_ready), .rf_wdat(rf_wdat), .rf_rdidx(rf_rdidx),
    .excp_valid(excp_valid), .excp_ready(excp_ready), .excp_itag(excp_itag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ITAG_W-1:0] itag;
    bit                rdwen;
    logic [4:0]        rdidx;
    logic [31:0]       data;
    bit                err;
    bit                issued;
  } rec_t;

  typedef struct {
    bit                is_excp;
    logic [ITAG_W-1:0] itag;
    logic [4:0]        rdidx;
    logic [31:0]       data;
  } evt_t;

  rec_t        mq[$];     // outstanding instructions, program order
  evt_t        expq[$];   // expected long-pipe retire events, program order
  int          disp_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  bit          drv_en = 0, disp_en = 0;
  bit          lsu_fired = 0, nice_fired = 0, alu_fired = 0;
  logic [31:0] drv_data;
  bit          drv_err;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    disp_valid = 0; disp_rdwen = 0; disp_rdidx = 0;
    disp_rs1en = 0; disp_rs2en = 0; disp_rs1idx = 0; disp_rs2idx = 0;
    lsu_wbck_valid = 0; lsu_wbck_wdat = 0; lsu_wbck_itag = 0; lsu_wbck_err = 0;
    nice_wbck_valid = 0; nice_wbck_wdat = 0; nice_wbck_itag = 0; nice_wbck_err = 0;
    alu_wbck_valid = 0; alu_wbck_wdat = 0; alu_wbck_rdidx = 0;
    rf_ready = 0; excp_ready = 0;
    drv_data = 0; drv_err = 0;
  endtask

  // Give a not-yet-returned instruction to a result source, never letting
  // both sources sit on non-head results while the head is unreturned.
  task automatic assign_slot(input bit to_nice);
    int                cand[$];
    int                pick;
    bit                other_busy;
    logic [ITAG_W-1:0] other_tag;
    if (mq.size() == 0) return;
    other_busy = to_nice ? lsu_wbck_valid : nice_wbck_valid;
    other_tag  = to_nice ? lsu_wbck_itag : nice_wbck_itag;
    if (other_busy && other_tag != mq[0].itag && !mq[0].issued) begin
      pick = 0;
    end else begin
      foreach (mq[i]) if (!mq[i].issued) cand.push_back(i);
      if (cand.size() == 0) return;
      pick = cand[$urandom_range(0, cand.size() - 1)];
    end
    mq[pick].issued = 1;
    if (to_nice) begin
      nice_wbck_valid = 1; nice_wbck_itag = mq[pick].itag;
      nice_wbck_wdat = mq[pick].data; nice_wbck_err = mq[pick].err;
    end else begin
      lsu_wbck_valid = 1; lsu_wbck_itag = mq[pick].itag;
      lsu_wbck_wdat = mq[pick].data; lsu_wbck_err = mq[pick].err;
    end
  endtask

  // Driver: new stimulus shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (drv_en) begin
      disp_valid  = disp_en && ($urandom_range(0, 99) < 55);
      disp_rdwen  = ($urandom_range(0, 3) != 0);
      disp_rdidx  = 5'($urandom_range(0, 7));
      disp_rs1en  = $urandom_range(0, 1);
      disp_rs2en  = $urandom_range(0, 1);
      disp_rs1idx = 5'($urandom_range(0, 7));
      disp_rs2idx = 5'($urandom_range(0, 7));
      drv_data    = $urandom;
      drv_err     = ($urandom_range(0, 9) == 0);
      if (lsu_fired) begin lsu_wbck_valid = 0; lsu_fired = 0; end
      if (nice_fired) begin nice_wbck_valid = 0; nice_fired = 0; end
      if (!lsu_wbck_valid && $urandom_range(0, 1) == 1) assign_slot(1'b0);
      if (!nice_wbck_valid && $urandom_range(0, 1) == 1) assign_slot(1'b1);
      if (alu_fired || !alu_wbck_valid) begin
        alu_fired      = 0;
        alu_wbck_valid = ($urandom_range(0, 99) < 30);
        alu_wbck_wdat  = $urandom;
        alu_wbck_rdidx = 5'($urandom_range(0, 31));
      end
      rf_ready   = ($urandom_range(0, 99) < 75);
      excp_ready = ($urandom_range(0, 99) < 60);
    end
  end

  // Monitor / scoreboard: sample on the falling edge, predict from the model.
  always @(negedge clk) begin
    bit   lf, nf, af, raw, waw, hm;
    rec_t r;
    evt_t e;
    if (rst) begin
      check("rst_lsu_ready", lsu_wbck_ready, 0);
      check("rst_nice_ready", nice_wbck_ready, 0);
      check("rst_alu_ready", alu_wbck_ready, 0);
      mq.delete();
      expq.delete();
      disp_cnt   = 0;
      lsu_fired  = 0;
      nice_fired = 0;
      alu_fired  = 0;
    end else begin
      lf = lsu_wbck_valid && lsu_wbck_ready;
      nf = nice_wbck_valid && nice_wbck_ready;
      af = alu_wbck_valid && alu_wbck_ready;
      check("disp_ready", disp_ready, mq.size() < DEPTH);
      check("oitf_empty", oitf_empty, mq.size() == 0);
      check("disp_itag", disp_itag, disp_cnt % DEPTH);
      if (disp_valid) begin
        raw = 0;
        waw = 0;
        foreach (mq[i]) begin
          if (mq[i].rdwen) begin
            if ((disp_rs1en && mq[i].rdidx == disp_rs1idx) ||
                (disp_rs2en && mq[i].rdidx == disp_rs2idx)) raw = 1;
            if (disp_rdwen && mq[i].rdidx == disp_rdidx) waw = 1;
          end
        end
        check("dep_raw", dep_raw, raw);
        check("dep_waw", dep_waw, waw);
      end
      hm = (mq.size() > 0) &&
           ((lsu_wbck_valid && lsu_wbck_itag == mq[0].itag) ||
            (nice_wbck_valid && nice_wbck_itag == mq[0].itag));
      check("alu_ready", alu_wbck_ready, !hm && rf_ready);
      check("dual_fire", lf && nf, 0);
      if (lf) check("lsu_retire_head", (mq.size() > 0) && (lsu_wbck_itag == mq[0].itag), 1);
      if (nf) check("nice_retire_head", (mq.size() > 0) && (nice_wbck_itag == mq[0].itag), 1);
      if (excp_valid && excp_ready) begin
        check("excp_expected", (expq.size() > 0) && expq[0].is_excp, 1);
        if (expq.size() > 0 && expq[0].is_excp) begin
          e = expq.pop_front();
          check("excp_itag", excp_itag, e.itag);
        end
      end
      if (af) begin
        check("alu_wen", rf_wen, 1);
        check("alu_rdidx", rf_rdidx, alu_wbck_rdidx);
        check("alu_wdat", rf_wdat, alu_wbck_wdat);
      end else if (rf_wen && rf_ready) begin
        check("wr_expected", (expq.size() > 0) && !expq[0].is_excp, 1);
        if (expq.size() > 0 && !expq[0].is_excp) begin
          e = expq.pop_front();
          check("wr_rdidx", rf_rdidx, e.rdidx);
          check("wr_wdat", rf_wdat, e.data);
        end
      end
      if ((lf || nf) && mq.size() > 0) void'(mq.pop_front());
      if (disp_valid && disp_ready) begin
        r.itag   = ITAG_W'(disp_cnt % DEPTH);
        r.rdwen  = disp_rdwen;
        r.rdidx  = disp_rdidx;
        r.data   = drv_data;
        r.err    = drv_err;
        r.issued = 0;
        mq.push_back(r);
        e.is_excp = drv_err;
        e.itag    = r.itag;
        e.rdidx   = r.rdidx;
        e.data    = r.data;
        if (drv_err || disp_rdwen) expq.push_back(e);
        disp_cnt++;
      end
      if (lf) lsu_fired = 1;
      if (nf) nice_fired = 1;
      if (af) alu_fired = 1;
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    disp_en = 0;
    while ((mq.size() != 0 || lsu_wbck_valid || nice_wbck_valid) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check({nm, "_timeout"}, n < 4000, 1);
    @(negedge clk);
    #1;
    check({nm, "_expq_empty"}, expq.size(), 0);
    check({nm, "_oitf_empty"}, oitf_empty, 1);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    @(negedge clk);
    #1;
    check("reset_disp_ready", disp_ready, 1);
    check("reset_oitf_empty", oitf_empty, 1);
    check("reset_disp_itag", disp_itag, 0);
    check("reset_dep_raw", dep_raw, 0);
    check("reset_dep_waw", dep_waw, 0);
    check("reset_lsu_ready", lsu_wbck_ready, 0);
    check("reset_nice_ready", nice_wbck_ready, 0);
    check("reset_alu_ready", alu_wbck_ready, 0);
    check("reset_rf_wen", rf_wen, 0);
    check("reset_excp_valid", excp_valid, 0);

    drv_en  = 1;
    disp_en = 1;
    repeat (1500) @(posedge clk);
    drain("drain1");

    // Reset in the middle of traffic, with requests still pending.
    disp_en = 1;
    repeat (300) @(posedge clk);
    #2;
    drv_en     = 0;
    rst        = 1;
    rf_ready   = 1;
    excp_ready = 1;
    @(posedge clk);
    #2;
    rst = 0;
    clear_inputs();
    @(negedge clk);
    #1;
    check("midrst_oitf_empty", oitf_empty, 1);
    check("midrst_disp_itag", disp_itag, 0);
    check("midrst_disp_ready", disp_ready, 1);
    check("midrst_excp_valid", excp_valid, 0);
    check("midrst_rf_wen", rf_wen, 0);

    drv_en  = 1;
    disp_en = 1;
    repeat (400) @(posedge clk);
    drain("drain2");

    drv_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
